// File: rtl/inst_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : inst_dispatcher
//  Description : Issue-side front end of the Tomasulo core. Decoded
//                instructions are held in a small in-order queue. On each
//                dispatch the next reorder-buffer entry is allocated, and the
//                head goes to the lowest-indexed idle function unit whose
//                opcode matches. The block drives the fu / RB_index / inst
//                broadcast and owns reset_bus to the function units.
//  Options     : DISPATCH_BYPASS_EN - when defined, an instruction arriving
//                while the queue is empty can dispatch on the same posedge it
//                is accepted, without occupying a queue slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_dispatcher #(
    parameter int                                WORD_SIZE    = 32,
    parameter int                                OPCODE_WIDTH = 5,
    parameter int                                FU_NUM       = 4,
    parameter int                                FU_INDEX     = 3,
    parameter logic [FU_NUM*OPCODE_WIDTH-1:0]    FU_OPMAP     = {5'd3, 5'd2, 5'd1, 5'd0},
    parameter int                                RB_SIZE      = 8,
    parameter int                                RB_INDEX     = 3,
    parameter int                                QUEUE_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [WORD_SIZE-1:0]    inst_in,
    input  logic                    inst_valid,
    output logic                    inst_ready,
    input  logic                    flush,
    input  logic                    rb_commit,
    input  logic [FU_NUM-1:0]       busy_out,
    output logic [FU_INDEX-1:0]     fu,
    output logic [RB_INDEX-1:0]     RB_index,
    output logic [WORD_SIZE-1:0]    inst,
    output logic                    rb_alloc,
    output logic [FU_NUM-1:0]       reset_bus
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int QPTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QCNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int RBU_W  = $clog2(RB_SIZE + 1);

    localparam logic [FU_INDEX-1:0] FU_NULL   = '1;
    localparam logic [QCNT_W-1:0]   QDEPTH_C  = QCNT_W'(QUEUE_DEPTH);
    localparam logic [RBU_W-1:0]    RB_SIZE_C = RBU_W'(RB_SIZE);
    localparam logic [RB_INDEX-1:0] RB_LAST_C = RB_INDEX'(RB_SIZE - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WORD_SIZE-1:0] q_mem_q [QUEUE_DEPTH];
    logic [QPTR_W-1:0]    rd_ptr_q,     rd_ptr_d;
    logic [QPTR_W-1:0]    wr_ptr_q,     wr_ptr_d;
    logic [QCNT_W-1:0]    count_q,      count_d;
    logic [RB_INDEX-1:0]  tail_q,       tail_d;
    logic [RBU_W-1:0]     rb_used_q,    rb_used_d;
    logic [FU_NUM-1:0]    pend_q,       pend_d;
    logic [FU_NUM-1:0]    pend_age_q,   pend_age_d;
    logic [FU_INDEX-1:0]  fu_q,         fu_d;
    logic [RB_INDEX-1:0]  rb_index_q,   rb_index_d;
    logic [WORD_SIZE-1:0] inst_q,       inst_d;
    logic                 rb_alloc_q,   rb_alloc_d;
    logic [FU_NUM-1:0]    reset_bus_q,  reset_bus_d;
    logic                 rst_hold_q,   rst_hold_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                    q_empty;
    logic                    push_req;
    logic                    q_write;
    logic                    q_pop;
    logic [WORD_SIZE-1:0]    head_inst;
    logic [WORD_SIZE-1:0]    src_inst;
    logic                    src_valid;
    logic [OPCODE_WIDTH-1:0] src_opcode;
    logic [FU_NUM-1:0]       match_w;
    logic                    any_match;
    logic [FU_INDEX-1:0]     sel_idx;
    logic                    rb_space;
    logic                    dispatch;
    logic                    commit_eff;

    assign q_empty    = (count_q == '0);
    assign inst_ready = (count_q < QDEPTH_C);
    assign head_inst  = q_mem_q[rd_ptr_q];

    // A push in the flush cycle is dropped along with the queue contents.
    assign push_req   = inst_valid & inst_ready & ~flush;

`ifdef DISPATCH_BYPASS_EN
    // With an empty queue the candidate is the incoming instruction itself.
    assign src_inst   = q_empty ? inst_in : head_inst;
    assign src_valid  = q_empty ? push_req : 1'b1;
`else
    assign src_inst   = head_inst;
    assign src_valid  = ~q_empty;
`endif

    assign src_opcode = src_inst[WORD_SIZE-1 -: OPCODE_WIDTH];
    assign rb_space   = (rb_used_q < RB_SIZE_C);

    // Candidate FUs: opcode matches, reservation station idle, no dispatch
    // still in flight towards it.
    generate
        for (genvar gi = 0; gi < FU_NUM; gi++) begin : g_match
            assign match_w[gi] = (FU_OPMAP[gi*OPCODE_WIDTH +: OPCODE_WIDTH] == src_opcode)
                               & ~busy_out[gi] & ~pend_q[gi];
        end
    endgenerate

    // Lowest-indexed matching FU wins (scan downwards so the lowest is last).
    always_comb begin
        sel_idx   = FU_NULL;
        any_match = 1'b0;
        for (int i = FU_NUM - 1; i >= 0; i--) begin
            if (match_w[i]) begin
                sel_idx   = FU_INDEX'(i);
                any_match = 1'b1;
            end
        end
    end

    assign dispatch   = src_valid & rb_space & any_match & ~flush;
    // A bypassed instruction (queue empty) never touches the queue.
    assign q_pop      = dispatch & ~q_empty;
    assign q_write    = push_req & ~(dispatch & q_empty);
    // Commits are ignored on an empty reorder buffer and during flush.
    assign commit_eff = rb_commit & (rb_used_q != '0) & ~flush;

    // ------------------------------------------------------------------------
    // Next-state logic for pointers, counters, pend tracking and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        tail_d      = tail_q;
        rb_used_d   = rb_used_q;
        pend_d      = pend_q;
        pend_age_d  = pend_age_q;
        fu_d        = FU_NULL;
        rb_index_d  = rb_index_q;
        inst_d      = inst_q;
        rb_alloc_d  = 1'b0;
        rst_hold_d  = 1'b0;
        reset_bus_d = (rst_hold_q | flush) ? {FU_NUM{1'b1}} : {FU_NUM{1'b0}};

        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            tail_d     = '0;
            rb_used_d  = '0;
            pend_d     = '0;
            pend_age_d = '0;
        end else begin
            // Queue pointers and occupancy
            if (q_write) begin
                wr_ptr_d = wr_ptr_q + QPTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr_d = rd_ptr_q + QPTR_W'(1);
            end
            case ({q_write, q_pop})
                2'b10:   count_d = count_q + QCNT_W'(1);
                2'b01:   count_d = count_q - QCNT_W'(1);
                default: count_d = count_q;
            endcase

            // Reorder-buffer occupancy
            case ({dispatch, commit_eff})
                2'b10:   rb_used_d = rb_used_q + RBU_W'(1);
                2'b01:   rb_used_d = rb_used_q - RBU_W'(1);
                default: rb_used_d = rb_used_q;
            endcase

            // Pend ageing: drop on the first busy sample or after two cycles.
            for (int i = 0; i < FU_NUM; i++) begin
                if (pend_q[i]) begin
                    if (busy_out[i] || pend_age_q[i]) begin
                        pend_d[i] = 1'b0;
                    end else begin
                        pend_age_d[i] = 1'b1;
                    end
                end
            end

            if (dispatch) begin
                fu_d                = sel_idx;
                rb_index_d          = tail_q;
                inst_d              = src_inst;
                rb_alloc_d          = 1'b1;
                tail_d              = (tail_q == RB_LAST_C) ? '0 : tail_q + RB_INDEX'(1);
                pend_d[sel_idx]     = 1'b1;
                pend_age_d[sel_idx] = 1'b0;
            end
        end
    end

    // Control state and broadcast registers; reset aborts any dispatch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tail_q      <= '0;
            rb_used_q   <= '0;
            pend_q      <= '0;
            pend_age_q  <= '0;
            fu_q        <= FU_NULL;
            rb_index_q  <= '0;
            inst_q      <= '0;
            rb_alloc_q  <= 1'b0;
            reset_bus_q <= {FU_NUM{1'b1}};
            rst_hold_q  <= 1'b1;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            tail_q      <= tail_d;
            rb_used_q   <= rb_used_d;
            pend_q      <= pend_d;
            pend_age_q  <= pend_age_d;
            fu_q        <= fu_d;
            rb_index_q  <= rb_index_d;
            inst_q      <= inst_d;
            rb_alloc_q  <= rb_alloc_d;
            reset_bus_q <= reset_bus_d;
            rst_hold_q  <= rst_hold_d;
        end
    end

    // Queue storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (q_write) begin
            q_mem_q[wr_ptr_q] <= inst_in;
        end
    end

    assign fu        = fu_q;
    assign RB_index  = rb_index_q;
    assign inst      = inst_q;
    assign rb_alloc  = rb_alloc_q;
    assign reset_bus = reset_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_dispatcher
//  Description : Self-checking bench for inst_dispatcher. Expected dispatches
//                are queued when an instruction is handed over and compared
//                in order against the dispatches seen on the broadcast.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_dispatcher;

    // FU0 <- op1, FU1 <- op3, FU2 <- op3, FU3 <- op2
    localparam logic [19:0] C_OPMAP = {5'd2, 5'd3, 5'd3, 5'd1};
`ifdef DISPATCH_BYPASS_EN
    localparam int C_LAT = 0;
`else
    localparam int C_LAT = 1;
`endif

    typedef struct packed {
        logic [2:0]  fu;
        logic [2:0]  rb;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        inst_ready;
    logic        flush;
    logic        rb_commit;
    logic [3:0]  busy_out;
    logic [2:0]  fu;
    logic [2:0]  RB_index;
    logic [31:0] inst;
    logic        rb_alloc;
    logic [3:0]  reset_bus;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [2:0] exp_tail = 3'd0;

    int   cyc    = 0;
    exp_t obs_mem [0:255];
    int   obs_cyc [0:255];
    int   obs_wr = 0;
    int   obs_rd = 0;

    inst_dispatcher #(
        .WORD_SIZE    (32),
        .OPCODE_WIDTH (5),
        .FU_NUM       (4),
        .FU_INDEX     (3),
        .FU_OPMAP     (C_OPMAP),
        .RB_SIZE      (8),
        .RB_INDEX     (3),
        .QUEUE_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .inst_in    (inst_in),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .flush      (flush),
        .rb_commit  (rb_commit),
        .busy_out   (busy_out),
        .fu         (fu),
        .RB_index   (RB_index),
        .inst       (inst),
        .rb_alloc   (rb_alloc),
        .reset_bus  (reset_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record every dispatch seen on the broadcast, mid-cycle.
    always @(negedge clk) begin
        if (rb_alloc && obs_wr < 256) begin
            obs_mem[obs_wr] <= {fu, RB_index, inst};
            obs_cyc[obs_wr] <= cyc;
            obs_wr          <= obs_wr + 1;
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [26:0] tag);
        return {op, tag};
    endfunction

    // Hand one instruction over; optionally queue its expected dispatch.
    task automatic push_inst(input logic [31:0] d, input logic [2:0] efu, input bit expect_it);
        int   g;
        exp_t e;
        g          = 0;
        inst_in    = d;
        inst_valid = 1'b1;
        while (!inst_ready && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (!inst_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: inst_ready=%0b after %0d cycles, required 1", inst_ready, g);
        end else if (expect_it) begin
            e.fu   = efu;
            e.rb   = exp_tail;
            e.inst = d;
            sb.push_back(e);
            exp_tail = exp_tail + 3'd1;
        end
        @(posedge clk); #1;
        inst_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget, input string name);
        int g;
        g = 0;
        while ((obs_wr - obs_rd) < n && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        if ((obs_wr - obs_rd) < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d dispatches seen, required %0d", name, obs_wr - obs_rd, n);
        end
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        rb_commit  = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        exp_tail = 3'd0;
        sb.delete();
        obs_rd = obs_wr;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (fu !== 3'd7 || rb_alloc !== 1'b0 || RB_index !== 3'd0 || inst !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: fu=%0d rb_alloc=%0b RB_index=%0d inst=%h, required 7 0 0 0", fu, rb_alloc, RB_index, inst);
        end
        n_checks++;
        if (reset_bus !== 4'b1111 || inst_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bus_held: reset_bus=%b inst_ready=%0b, required 1111 1", reset_bus, inst_ready);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (reset_bus !== 4'b1111 || fu !== 3'd7) begin
            n_fail++;
            $display("FAIL reset_release1: reset_bus=%b fu=%0d, required 1111 7", reset_bus, fu);
        end
        @(posedge clk); #1;
        n_checks++;
        if (reset_bus !== 4'b0000 || inst_ready !== 1'b1 || fu !== 3'd7) begin
            n_fail++;
            $display("FAIL reset_release2: reset_bus=%b inst_ready=%0b fu=%0d, required 0000 1 7", reset_bus, inst_ready, fu);
        end
    endtask

    task automatic test_single_dispatch();
        logic [31:0] d;
        exp_t        e;
        exp_t        o;
        int          n;
        d        = mk(5'd3, 27'h00000A1);
        busy_out = 4'b0010;
        push_inst(d, 3'd2, 1'b1);
        n = cyc;
        repeat (C_LAT) begin @(posedge clk); #1; end
        n_checks++;
        if (fu !== 3'd2 || rb_alloc !== 1'b1 || RB_index !== 3'd0 || inst !== d) begin
            n_fail++;
            $display("FAIL single_dispatch: fu=%0d rb_alloc=%0b RB_index=%0d inst=%h, required 2 1 0 %h", fu, rb_alloc, RB_index, inst, d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (fu !== 3'd7 || rb_alloc !== 1'b0 || RB_index !== 3'd0 || inst !== d) begin
            n_fail++;
            $display("FAIL single_after: fu=%0d rb_alloc=%0b RB_index=%0d inst=%h, required 7 0 0 %h", fu, rb_alloc, RB_index, inst, d);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (obs_rd < obs_wr && obs_cyc[obs_rd] !== n + C_LAT) begin
            n_fail++;
            $display("FAIL single_latency: dispatch at cycle %0d, required %0d", obs_cyc[obs_rd], n + C_LAT);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL single_sb: no dispatch, required fu=%0d rb=%0d inst=%h", e.fu, e.rb, e.inst);
            end else begin
                o = obs_mem[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL single_sb: fu=%0d rb=%0d inst=%h, required fu=%0d rb=%0d inst=%h", o.fu, o.rb, o.inst, e.fu, e.rb, e.inst);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL single_extra: %0d unexpected dispatches, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_fu_select_stall();
        exp_t e;
        exp_t o;
        busy_out = 4'b0010;
        push_inst(mk(5'd3, 27'h0000111), 3'd2, 1'b1);
        push_inst(mk(5'd3, 27'h0000112), 3'd1, 1'b1);
        // Reservation station 2 has now taken the first instruction.
        busy_out = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rb_alloc !== 1'b0 || fu !== 3'd7) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d fu=%0d rb_alloc=%0b, required 7 0", k, fu, rb_alloc);
            end
        end
        busy_out = 4'b0100;
        wait_obs(2, 20, "stall");
        repeat (3) begin @(posedge clk); #1; end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL stall_sb: no dispatch, required fu=%0d rb=%0d inst=%h", e.fu, e.rb, e.inst);
            end else begin
                o = obs_mem[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL stall_sb: fu=%0d rb=%0d inst=%h, required fu=%0d rb=%0d inst=%h", o.fu, o.rb, o.inst, e.fu, e.rb, e.inst);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL stall_extra: %0d unexpected dispatches, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
        busy_out = 4'b0000;
    endtask

    task automatic test_rb_full_wrap();
        logic [4:0] ops [3];
        logic [2:0] fus [3];
        exp_t       e;
        exp_t       o;
        int         k;
        int         prev;
        ops[0] = 5'd1; ops[1] = 5'd3; ops[2] = 5'd2;
        fus[0] = 3'd0; fus[1] = 3'd1; fus[2] = 3'd3;
        apply_reset();
        busy_out = 4'b0000;
        for (int i = 0; i < 9; i++) begin
            push_inst(mk(ops[i % 3], 27'(32'h200 + i)), fus[i % 3], 1'b1);
        end
        wait_obs(8, 20, "rbfull");
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rb_alloc !== 1'b0 || fu !== 3'd7) begin
                n_fail++;
                $display("FAIL rbfull_stall: cycle %0d fu=%0d rb_alloc=%0b, required 7 0", j, fu, rb_alloc);
            end
        end
        rb_commit = 1'b1;
        @(posedge clk); #1;
        rb_commit = 1'b0;
        n_checks++;
        if (rb_alloc !== 1'b0) begin
            n_fail++;
            $display("FAIL rbfull_commit_edge: rb_alloc=%0b, required 0", rb_alloc);
        end
        wait_obs(9, 20, "rbwrap");
        repeat (3) begin @(posedge clk); #1; end
        k    = 0;
        prev = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL rbfull_sb: no dispatch, required fu=%0d rb=%0d inst=%h", e.fu, e.rb, e.inst);
            end else begin
                o = obs_mem[obs_rd];
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rbfull_sb: fu=%0d rb=%0d inst=%h, required fu=%0d rb=%0d inst=%h", o.fu, o.rb, o.inst, e.fu, e.rb, e.inst);
                end
                if (k > 0 && k < 8) begin
                    n_checks++;
                    if (obs_cyc[obs_rd] !== prev + 1) begin
                        n_fail++;
                        $display("FAIL rbfull_throughput: dispatch %0d at cycle %0d, required %0d", k, obs_cyc[obs_rd], prev + 1);
                    end
                end
                prev = obs_cyc[obs_rd];
                obs_rd++;
            end
            k++;
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL rbfull_extra: %0d unexpected dispatches, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_queue_full();
        logic [31:0] fifth;
        exp_t        e;
        exp_t        o;
        int          prev;
        int          k;
        apply_reset();
        busy_out = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            push_inst(mk(5'd1, 27'(32'h300 + i)), 3'd0, 1'b1);
        end
        n_checks++;
        if (inst_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL qfull_ready: inst_ready=%0b, required 0", inst_ready);
        end
        fifth      = mk(5'd1, 27'h0000304);
        inst_in    = fifth;
        inst_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            n_checks++;
            if (inst_ready !== 1'b0 || rb_alloc !== 1'b0) begin
                n_fail++;
                $display("FAIL qfull_hold: cycle %0d inst_ready=%0b rb_alloc=%0b, required 0 0", j, inst_ready, rb_alloc);
            end
        end
        busy_out = 4'b0000;
        push_inst(fifth, 3'd0, 1'b1);
        wait_obs(5, 60, "qfull");
        repeat (3) begin @(posedge clk); #1; end
        k    = 0;
        prev = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL qfull_sb: no dispatch, required fu=%0d rb=%0d inst=%h", e.fu, e.rb, e.inst);
            end else begin
                o = obs_mem[obs_rd];
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL qfull_sb: fu=%0d rb=%0d inst=%h, required fu=%0d rb=%0d inst=%h", o.fu, o.rb, o.inst, e.fu, e.rb, e.inst);
                end
                if (k > 0) begin
                    n_checks++;
                    if (obs_cyc[obs_rd] - prev < 2) begin
                        n_fail++;
                        $display("FAIL qfull_spacing: same-FU gap %0d cycles, required at least 2", obs_cyc[obs_rd] - prev);
                    end
                end
                prev = obs_cyc[obs_rd];
                obs_rd++;
            end
            k++;
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL qfull_extra: %0d unexpected dispatches, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    task automatic test_flush();
        exp_t e;
        exp_t o;
        busy_out = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            push_inst(mk(5'd3, 27'(32'h400 + i)), 3'd1, 1'b0);
        end
        flush      = 1'b1;
        inst_in    = mk(5'd3, 27'h00004FF);
        inst_valid = 1'b1;
        @(posedge clk); #1;
        flush      = 1'b0;
        inst_valid = 1'b0;
        busy_out   = 4'b0000;
        n_checks++;
        if (reset_bus !== 4'b1111 || inst_ready !== 1'b1 || fu !== 3'd7 || rb_alloc !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: reset_bus=%b inst_ready=%0b fu=%0d rb_alloc=%0b, required 1111 1 7 0", reset_bus, inst_ready, fu, rb_alloc);
        end
        @(posedge clk); #1;
        n_checks++;
        if (reset_bus !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_reset_bus: reset_bus=%b, required 0000", reset_bus);
        end
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL flush_queue_empty: %0d dispatches after flush, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
        exp_tail = 3'd0;
        push_inst(mk(5'd3, 27'h0000500), 3'd1, 1'b1);
        wait_obs(1, 20, "flush");
        repeat (3) begin @(posedge clk); #1; end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (obs_rd >= obs_wr) begin
                n_fail++;
                $display("FAIL flush_sb: no dispatch, required fu=%0d rb=%0d inst=%h", e.fu, e.rb, e.inst);
            end else begin
                o = obs_mem[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL flush_sb: fu=%0d rb=%0d inst=%h, required fu=%0d rb=%0d inst=%h", o.fu, o.rb, o.inst, e.fu, e.rb, e.inst);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_wr) begin
            n_fail++;
            $display("FAIL flush_extra: %0d unexpected dispatches, required 0", obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        inst_in    = 32'd0;
        inst_valid = 1'b0;
        flush      = 1'b0;
        rb_commit  = 1'b0;
        busy_out   = 4'b0000;
        #1;
        test_reset();
        test_single_dispatch();
        test_fu_select_stall();
        test_rb_full_wrap();
        test_queue_full();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
